// File: rtl/stream_arbiter_if.sv
// Valid/ready bundle between OUTPUT_NUM upstream channels and one downstream port.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface stream_arbiter_if #(
    parameter int OUTPUT_NUM = 5,
    parameter int DATA_WIDTH = 16
);
    logic [OUTPUT_NUM*DATA_WIDTH-1:0] data_i;
    logic [OUTPUT_NUM-1:0]            valid_i;
    logic [OUTPUT_NUM-1:0]            ready_o;
    logic [DATA_WIDTH-1:0]            data_o;
    logic                             valid_o;
    logic                             ready_i;

    modport slave (
        input  data_i,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output data_o,
        output valid_o
    );

    modport master (
        output data_i,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  data_o,
        input  valid_o
    );
endinterface

// File: rtl/stream_arbiter.sv
// N-to-1 round-robin stream arbiter with a zero-latency datapath.
// The grant is locked while downstream stalls so that the output word stays stable.
module stream_arbiter #(
    parameter int OUTPUT_NUM = 5,
    parameter int DATA_WIDTH = 16
) (
    input logic              ACLK,
    input logic              ARESETn,
    stream_arbiter_if.slave  s
);
    localparam int PW = $clog2(OUTPUT_NUM);
    typedef logic [PW-1:0] idx_t;

    idx_t ptr_q, ptr_d;
    idx_t lock_idx_q, lock_idx_d;
    logic locked_q, locked_d;
    idx_t grant;
    logic found;
    logic valid_int;
    int   j;

    // Search order starts at ptr and wraps; a held lock overrides the search
    always_comb begin
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < OUTPUT_NUM; i++) begin
            j = (int'(ptr_q) + i) % OUTPUT_NUM;
            if (!found && s.valid_i[j]) begin
                grant = idx_t'(j);
                found = 1'b1;
            end
        end
        if (locked_q) begin
            grant = lock_idx_q;
        end
    end

    assign valid_int = locked_q | (|s.valid_i);

    // ARESETn is active-high: outputs are live only when it is low
    always_comb begin
        s.valid_o = 1'b0;
        s.data_o  = '0;
        s.ready_o = '0;
        if (!ARESETn && valid_int) begin
            s.valid_o = 1'b1;
            s.data_o  = s.data_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            for (int i = 0; i < OUTPUT_NUM; i++) begin
                s.ready_o[i] = s.ready_i && (grant == idx_t'(i));
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (valid_int) begin
            if (s.ready_i) begin
                ptr_d    = (grant == idx_t'(OUTPUT_NUM - 1)) ? '0 : grant + 1'b1;
                locked_d = 1'b0;
            end else begin
                locked_d   = 1'b1;
                lock_idx_d = grant;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end
endmodule

// File: tb/tb_stream_arbiter.sv
// Directed and random checks of stream_arbiter against a queue scoreboard.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_stream_arbiter;
    localparam int N = 5;
    localparam int W = 16;

    logic ACLK = 1'b0;
    logic ARESETn;

    stream_arbiter_if #(.OUTPUT_NUM(N), .DATA_WIDTH(W)) bus ();

    stream_arbiter #(.OUTPUT_NUM(N), .DATA_WIDTH(W)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .s       (bus)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [2:0]   ch;
        logic [W-1:0] word;
        logic [N-1:0] rdy;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [N-1:0] pend = '0;
    int           waits[N];
    int           m_ptr = 0;
    bit           m_locked = 0;
    int           m_lock = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_data = '0;
    int           seq = 0;

    logic [W-1:0] rr_w[6] = '{16'hEEEE, 16'hDDDD, 16'hCCCC,
                              16'hBBBB, 16'hAAAA, 16'hEEEE};
    logic [N-1:0] rr_r[6] = '{5'b00001, 5'b00010, 5'b00100,
                              5'b01000, 5'b10000, 5'b00001};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r,
                         input logic rst);
        @(negedge ACLK);
        ARESETn     = rst;
        bus.valid_i = v;
        bus.ready_i = r;
        #1;
    endtask

    task automatic push(input logic [W-1:0] w, input logic [N-1:0] rdy);
        sb.push_back('{ch: 3'd0, word: w, rdy: rdy});
    endtask

    task automatic observe(input string tag);
        exp_t e;
        if (bus.valid_o && bus.ready_i) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_data"}, bus.data_o, e.word);
                chk({tag, "_ready"}, bus.ready_o, e.rdy);
            end
        end else begin
            chk({tag, "_handshake"}, bus.valid_o & bus.ready_i, 1);
        end
    endtask

    function automatic int find(input int c);
        for (int k = 0; k < sb.size(); k++) begin
            if (int'(sb[k].ch) == c) return k;
        end
        return -1;
    endfunction

    task automatic rnd_step(input bit allow_new);
        logic         r;
        logic         ev;
        int           g;
        int           k;
        logic [W-1:0] ew;
        logic [N-1:0] er;
        if (allow_new) begin
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && ($urandom_range(0, 1) == 1)) begin
                    seq++;
                    pend[c] = 1'b1;
                    ew = {3'(c), 13'(seq)};
                    bus.data_i[c*W +: W] = ew;
                    sb.push_back('{ch: 3'(c), word: ew, rdy: N'(1) << c});
                    waits[c] = 0;
                end
            end
        end
        r = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
        drive(pend, r, 1'b0);
        ev = m_locked || (|pend);
        g  = m_lock;
        if (!m_locked) begin
            g = 0;
            for (int i = N - 1; i >= 0; i--) begin
                int jj = (m_ptr + i) % N;
                if (pend[jj]) g = jj;
            end
        end
        chk("rnd_valid", bus.valid_o, ev);
        if (ev) begin
            k  = find(g);
            ew = (k >= 0) ? sb[k].word : '0;
            er = r ? (N'(1) << g) : '0;
            chk("rnd_ready", bus.ready_o, er);
            chk("rnd_data", bus.data_o, ew);
            if (prev_stall) chk("rnd_stable", bus.data_o, prev_data);
            if (r) begin
                chk("rnd_wait", 32'(waits[g] <= N - 1), 1);
                if (k >= 0) sb.delete(k);
                pend[g] = 1'b0;
                for (int c = 0; c < N; c++) begin
                    if (pend[c]) waits[c]++;
                end
                m_ptr    = (g + 1) % N;
                m_locked = 0;
            end else begin
                m_locked = 1;
                m_lock   = g;
            end
            prev_stall = !r;
            prev_data  = ew;
        end else begin
            prev_stall = 0;
        end
    endtask

    initial begin
        ARESETn     = 1'b1;
        bus.valid_i = '0;
        bus.ready_i = 1'b1;
        bus.data_i  = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE};

        drive(5'b00000, 1'b1, 1'b1);
        chk("rst_idle_valid", bus.valid_o, 0);
        chk("rst_idle_ready", bus.ready_o, 0);
        drive(5'b11111, 1'b1, 1'b1);
        chk("rst_req_valid", bus.valid_o, 0);
        chk("rst_req_ready", bus.ready_o, 0);
        chk("rst_req_data", bus.data_o, 0);

        for (int k = 0; k < 6; k++) begin
            push(rr_w[k], rr_r[k]);
            drive(5'b11111, 1'b1, 1'b0);
            chk("rr_valid", bus.valid_o, 1);
            observe("rr");
        end

        for (int k = 0; k < 3; k++) begin
            drive(5'b00100, 1'b0, 1'b0);
            chk("stall_valid", bus.valid_o, 1);
            chk("stall_ready", bus.ready_o, 0);
            chk("stall_data", bus.data_o, 16'hCCCC);
        end
        drive(5'b00101, 1'b0, 1'b0);
        chk("stall_hi_ready", bus.ready_o, 0);
        chk("stall_hi_data", bus.data_o, 16'hCCCC);
        push(16'hCCCC, 5'b00100);
        drive(5'b00101, 1'b1, 1'b0);
        observe("stall_xfer");
        push(16'hEEEE, 5'b00001);
        drive(5'b00001, 1'b1, 1'b0);
        observe("stall_next");

        push(16'hAAAA, 5'b10000);
        drive(5'b10000, 1'b1, 1'b0);
        observe("wrap_ch4");
        push(16'hEEEE, 5'b00001);
        drive(5'b10001, 1'b1, 1'b0);
        observe("wrap_ch0");
        push(16'hAAAA, 5'b10000);
        drive(5'b10000, 1'b1, 1'b0);
        observe("wrap_ch4b");

        drive(5'b00000, 1'b1, 1'b0);
        chk("idle_valid", bus.valid_o, 0);
        chk("idle_ready", bus.ready_o, 0);
        chk("idle_data", bus.data_o, 0);

        drive(5'b00010, 1'b0, 1'b0);
        chk("midrst_lock_data", bus.data_o, 16'hDDDD);
        drive(5'b00010, 1'b0, 1'b1);
        chk("midrst_valid", bus.valid_o, 0);
        drive(5'b11111, 1'b0, 1'b0);
        chk("midrst_regrant", bus.data_o, 16'hEEEE);
        push(16'hEEEE, 5'b00001);
        drive(5'b11111, 1'b1, 1'b0);
        observe("midrst_xfer");

        drive(5'b01000, 1'b0, 1'b0);
        chk("drop_lock_data", bus.data_o, 16'hBBBB);
        drive(5'b00000, 1'b0, 1'b0);
        chk("drop_valid", bus.valid_o, 1);
        chk("drop_data", bus.data_o, 16'hBBBB);
        push(16'hBBBB, 5'b01000);
        drive(5'b01000, 1'b1, 1'b0);
        observe("drop_xfer");
        chk("directed_sb_empty", sb.size(), 0);

        drive(5'b00000, 1'b1, 1'b1);
        sb.delete();
        for (int c = 0; c < N; c++) waits[c] = 0;
        for (int cyc = 0; cyc < 200; cyc++) rnd_step(1'b1);
        for (int k = 0; k < 20 && pend != '0; k++) rnd_step(1'b0);
        chk("rnd_drained", pend, 0);
        chk("rnd_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- N-to-1 round-robin arbiter for valid/ready streams: OUTPUT_NUM requesters share one output stream carrying DATA_WIDTH-bit words.
- Sits at NoC router output stages and PMU merge points, where several upstream channels compete for one downstream channel.
- Zero-latency combinational datapath with a registered round-robin pointer and a registered grant lock that holds the selection stable while a transfer is stalled.

Parameters:
- OUTPUT_NUM, 5, number of requesting input streams; must be >= 2.
- DATA_WIDTH, 16, width of each data word.

Ports:
- ACLK  input  1  clock; all state updates on the rising edge.
- ARESETn  input  1  synchronous, active-high reset; reset is applied when ARESETn == 1 at a rising ACLK edge.
- data_i  input  OUTPUT_NUM*DATA_WIDTH  packed input words; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_i  input  OUTPUT_NUM  per-channel valid; bit i belongs to channel i.
- ready_o  output  OUTPUT_NUM  per-channel ready; bit i belongs to channel i.
- data_o  output  DATA_WIDTH  word of the granted channel.
- valid_o  output  1  output valid.
- ready_i  input  1  downstream ready.

Behaviour:
- State:
  - ptr: index of the highest-priority channel, width clog2(OUTPUT_NUM).
  - locked: 1 bit.
  - lock_idx: channel index held while locked.
- Reset (ARESETn == 1):
  - Next-state values: ptr = 0, locked = 0.
  - While reset is asserted, outputs are forced: valid_o = 0, ready_o = 0, data_o = 0.
- Grant selection, combinational:
  - If locked, grant = lock_idx.
  - Otherwise grant = the first i with valid_i[i] == 1, searching ptr, ptr+1, …, OUTPUT_NUM-1, 0, …, ptr-1, with modulo-OUTPUT_NUM wrap-around.
- Outputs:
  - valid_o = locked ? 1 : |valid_i.
  - data_o = word of channel grant. It is don't-care when valid_o = 0; the implementation drives 0 in that case.
  - ready_o[i] = ready_i & valid_o & (grant == i). At most one bit is set (one-hot or zero).
- Latency: zero cycles. Input-to-output is purely combinational, and transfer happens on the edge where valid_o & ready_i.
- Transfer edge (valid_o & ready_i): ptr <= (grant + 1) mod OUTPUT_NUM, locked <= 0.
- Stall edge (valid_o & !ready_i): locked <= 1, lock_idx <= grant, ptr unchanged.
  - The grant stays fixed until handshake, even if a higher-priority channel raises valid meanwhile.
  - data_o therefore stays stable, per stream protocol.
- Idle edge (valid_o == 0): no state change.
- Upstream rule: a requester must not drop valid_i[i] before its handshake. If a locked requester violates this, the lock is held anyway: valid_o stays 1 and data_o shows the current data_i of lock_idx.
- Fairness: after channel k is served, k becomes lowest priority. Each continuously requesting channel is served within OUTPUT_NUM transfers.
- Simultaneous events:
  - New requests arriving on the transfer edge are considered next cycle under the updated ptr.
  - A single requester is served back-to-back: every cycle that ready_i = 1 gives one transfer.
- Reset mid-transfer: the pending word is abandoned, and lock and ptr clear on that edge.
- No combinational path from ready_i to valid_o. A path from valid_i to ready_o is allowed.

Test Plan:
- Reset, then valid_i = 5'b00000, ready_i = 1 -> valid_o = 0, ready_o = 0; hold ARESETn = 1 with valid_i = 5'b11111 -> valid_o = 0, ready_o = 0.
- data_i channels 4..0 = AAAA, BBBB, CCCC, DDDD, EEEE; valid_i = 5'b11111 held, ready_i = 1 -> data_o sequence EEEE, DDDD, CCCC, BBBB, AAAA, EEEE; ready_o walks 00001, 00010, 00100, 01000, 10000.
- Stall: valid_i = 5'b00100, ready_i = 0 for 3 cycles, then raise valid_i[0] -> data_o stays CCCC, ready_o = 0; on ready_i = 1, ready_o = 5'b00100 with CCCC; next word is EEEE.
- Wrap-around: after serving channel 4, valid_i = 5'b10001 -> channel 0 (EEEE) granted before channel 4.
- Random: valid_i random 0..31, each bit self-clearing after its handshake, ready_i random, 200 cycles -> every request is served exactly once, ready_o one-hot or zero, data_o stable during stalls, no channel waits more than 5 transfers.
